// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Buffered 8N1 UART receiver (LSB first) with a first-word-fall-through FIFO.
// The line is oversampled at 16x the baud rate. The sample tick comes from a
// fractional phase accumulator, so a non-integer CLKFREQ/(16*BAUD) ratio
// produces jitter of at most one clk per tick and no cumulative rate error.
// Each bit is decided by a majority vote of the samples at phases 7, 8 and 9.
//
// Parameters:
//   CLKFREQ   clk frequency in Hz
//   BAUD      line rate in bits/s; CLKFREQ must be >= 64*BAUD
//   DEPTH     FIFO entries; a power of 2, >= 2
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   rx         in   serial line, idle high, asynchronous to clk
//   rd         in   pop strobe; ignored while valid=0
//   valid      out  FIFO non-empty
//   data       out  FIFO head byte; 8'h00 while valid=0
//   count      out  FIFO occupancy, 0..DEPTH
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a good byte was dropped because the FIFO was full
//   err_clr    in   clears frame_err and overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKFREQ = 69000000,
    parameter int BAUD    = 921600,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    output logic                   valid,
    output logic [7:0]             data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   err_clr
);

    localparam int ACC_W = $clog2(CLKFREQ) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(16 * BAUD);
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLKFREQ);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // 2-of-3 majority vote used to decide each bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_sum_s;
    logic             tick_r;

    logic             rx_meta_r;
    logic             rx_s;

    rx_state_t        state_r;
    logic [3:0]       ph_r;
    logic [2:0]       idx_r;
    logic             samp7_r;
    logic             samp8_r;
    logic             maj_s;
    logic [7:0]       shift_r;
    logic             push_r;
    logic             fe_set_r;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_nxt_s;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [PTR_W-1:0] count_cur_s;
    logic [PTR_W-1:0] count_nxt_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             ovr_set_s;
    logic [7:0]       head_nxt_s;

    logic             valid_r;
    logic [7:0]       data_r;
    logic [PTR_W-1:0] count_r;
    logic             frame_err_r;
    logic             overrun_r;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    assign acc_sum_s = acc_r + ACC_INC;

    // Fractional accumulator: one tick per 16th of a bit, remainder carried.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r  <= '0;
            tick_r <= 1'b0;
        end else if (acc_sum_s >= ACC_MOD) begin
            acc_r  <= acc_sum_s - ACC_MOD;
            tick_r <= 1'b1;
        end else begin
            acc_r  <= acc_sum_s;
            tick_r <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // The phase-9 sample is the live synchronised line; 7 and 8 were stored.
    assign maj_s = maj3(samp7_r, samp8_r, rx_s);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    // Frame FSM: advances on tick only; push/frame-error strobes last one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ph_r     <= 4'd0;
            idx_r    <= 3'd0;
            samp7_r  <= 1'b1;
            samp8_r  <= 1'b1;
            shift_r  <= 8'h00;
            push_r   <= 1'b0;
            fe_set_r <= 1'b0;
        end else begin
            push_r   <= 1'b0;
            fe_set_r <= 1'b0;
            if (tick_r) begin
                if (ph_r == 4'd7) begin
                    samp7_r <= rx_s;
                end
                if (ph_r == 4'd8) begin
                    samp8_r <= rx_s;
                end
                case (state_r)
                    ST_IDLE: begin
                        // The detecting tick counts as phase 0 of the start bit.
                        if (!rx_s) begin
                            ph_r    <= 4'd1;
                            state_r <= ST_START;
                        end else begin
                            ph_r <= 4'd0;
                        end
                    end
                    ST_START: begin
                        ph_r <= ph_r + 4'd1;
                        if ((ph_r == 4'd9) && maj_s) begin
                            state_r <= ST_IDLE;
                        end else if (ph_r == 4'd15) begin
                            idx_r   <= 3'd0;
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        ph_r <= ph_r + 4'd1;
                        if (ph_r == 4'd9) begin
                            shift_r <= {maj_s, shift_r[7:1]};
                        end
                        if (ph_r == 4'd15) begin
                            if (idx_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                idx_r <= idx_r + 3'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        ph_r <= ph_r + 4'd1;
                        // Leave half a bit early so the next start edge is not missed.
                        if (ph_r == 4'd9) begin
                            if (maj_s) begin
                                push_r  <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                fe_set_r <= 1'b1;
                                state_r  <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        // A held-low line must go high before a new frame can start.
                        if (rx_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign count_cur_s = wr_ptr_r - rd_ptr_r;
    assign full_s      = (count_cur_s == FULL_CNT);
    assign pop_s       = rd & valid_r;

    // Next-state pointers and head; a pop frees a slot for a same-cycle push.
    always_comb begin
        push_ok_s  = 1'b0;
        ovr_set_s  = 1'b0;
        head_nxt_s = 8'h00;
        if (push_r) begin
            if (!full_s || pop_s) begin
                push_ok_s = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else begin
            push_ok_s = 1'b0;
        end
        wr_nxt_s    = wr_ptr_r + PTR_W'(push_ok_s);
        rd_nxt_s    = rd_ptr_r + PTR_W'(pop_s);
        count_nxt_s = wr_nxt_s - rd_nxt_s;
        if (count_nxt_s == '0) begin
            head_nxt_s = 8'h00;
        end else if (push_ok_s && (wr_ptr_r[IDX_W-1:0] == rd_nxt_s[IDX_W-1:0])) begin
            // The byte being written is the new head: bypass the memory.
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s[IDX_W-1:0]];
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[IDX_W-1:0]] <= shift_r;
            end
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
        end
    end

    // Registered host-side view of the FIFO head and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            count_r <= '0;
        end else begin
            valid_r <= (count_nxt_s != '0);
            data_r  <= head_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    // A set event takes priority over a coincident err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (fe_set_r) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign valid     = valid_r;
    assign data      = data_r;
    assign count     = count_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule
